mux_rr_arbiter: RTL and testbench

Round-robin arbiter and scheduler that shares one N-input data mux among INPUTS requesters using valid/ready handshakes. It grants one requester per beat and allows bounded bursts of up to MAX_BURST consecutive beats per owner. It drives a registered output slot that carries the muxed data and the winning select index. It sits in front of shared-datapath consumers (PE operand buses, result write-back) that previously received hard-wired mux selects.

---
 rtl/mux_rr_arbiter.sv | 136 +++++++++++++
 tb/tb_mux_rr_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
// Round-robin arbiter that shares one N-input data mux among INPUTS
// requesters over valid/ready handshakes. An owner may hold the mux for up
// to MAX_BURST consecutive beats before the start pointer rotates past it.
// The winning beat lands in a registered output slot.
//
// State table
//   IDLE | no burst in progress; the winner is chosen round-robin from ptr
//   HOLD | owner has an unfinished burst and wins again while it stays valid
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   req_valid  per-requester valid
//   req_data   per-requester data (unpacked array)
//   req_ready  one-hot grant, or zero; qualified by the load condition
//   out_valid  the output slot holds a beat
//   out_data   data of the held beat
//   out_sel    index of the requester that supplied out_data
//   out_ready  the consumer takes the slot when out_valid is also high
//   burst_end  one-cycle pulse alongside the beat that completed a burst
module mux_rr_arbiter #(
  parameter int INPUTS     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 2,
  localparam int SW = $clog2(INPUTS),
  localparam int CW = $clog2(MAX_BURST + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INPUTS-1:0]     req_valid,
  input  logic [DATA_WIDTH-1:0] req_data [INPUTS],
  output logic [INPUTS-1:0]     req_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [SW-1:0]         out_sel,
  input  logic                  out_ready,
  output logic                  burst_end
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                fsm, fsm_n;
  logic [SW-1:0]         ptr, ptr_n;
  logic [SW-1:0]         owner, owner_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic                  out_valid_n;
  logic [DATA_WIDTH-1:0] out_data_n;
  logic [SW-1:0]         out_sel_n;
  logic                  burst_end_n;

  logic                  load_en;
  logic [SW-1:0]         win;
  logic                  found;
  int                    idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      burst_end <= 1'b0;
    end else begin
      fsm       <= fsm_n;
      ptr       <= ptr_n;
      owner     <= owner_n;
      cnt       <= cnt_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
      out_sel   <= out_sel_n;
      burst_end <= burst_end_n;
    end
  end

  always_comb begin
    // rst gates the load so no grant escapes while reset is asserted
    load_en = (!out_valid || out_ready) && (|req_valid) && !rst;

    win   = '0;
    found = 1'b0;
    idx   = 0;
    if (fsm == HOLD && req_valid[owner]) begin
      win   = owner;
      found = 1'b1;
    end else begin
      // wrap by subtraction so non-power-of-2 INPUTS stays in range
      for (int k = 0; k < INPUTS; k++) begin
        idx = int'(ptr) + k;
        if (idx >= INPUTS) idx = idx - INPUTS;
        if (!found && req_valid[idx[SW-1:0]]) begin
          win   = idx[SW-1:0];
          found = 1'b1;
        end
      end
    end

    for (int i = 0; i < INPUTS; i++) begin
      req_ready[i] = load_en && (win == SW'(i));
    end

    fsm_n       = fsm;
    ptr_n       = ptr;
    owner_n     = owner;
    cnt_n       = cnt;
    out_valid_n = out_valid;
    out_data_n  = out_data;
    out_sel_n   = out_sel;
    burst_end_n = 1'b0;

    if (load_en) begin
      out_valid_n = 1'b1;
      out_data_n  = req_data[win];
      out_sel_n   = win;
      if (fsm == HOLD && win == owner) begin
        cnt_n = cnt + CW'(1);
      end else begin
        owner_n = win;
        cnt_n   = CW'(1);
      end
      if (cnt_n == CW'(MAX_BURST)) begin
        fsm_n       = IDLE;
        ptr_n       = (win == SW'(INPUTS - 1)) ? '0 : win + SW'(1);
        burst_end_n = 1'b1;
      end else begin
        fsm_n = HOLD;
      end
    end else if (out_valid && out_ready) begin
      out_valid_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [DW-1:0] req_data [N];
  logic [N-1:0]  req_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_sel;
  logic          out_ready;
  logic          burst_end;

  mux_rr_arbiter #(.INPUTS(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sel(out_sel), .out_ready(out_ready), .burst_end(burst_end)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // behavioural model of the slot and the arbitration bookkeeping
  int m_valid, m_data, m_sel, m_be, m_ptr, m_owner, m_cnt, m_hold;

  int sel_log[$];
  int data_log[$];
  int be_log[$];
  int rdy_log[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_sel = 0; m_be = 0;
    m_ptr = 0; m_owner = 0; m_cnt = 0; m_hold = 0;
  endtask

  task automatic clear_logs();
    sel_log.delete(); data_log.delete(); be_log.delete(); rdy_log.delete();
  endtask

  // one clock: compare at the negedge, then advance the model across the posedge
  task automatic cycle();
    int load, w, exp_rdy;
    @(negedge clk);
    load = ((m_valid == 0 || out_ready) && req_valid != 0) ? 1 : 0;
    w = 0;
    if (m_hold != 0 && req_valid[m_owner]) w = m_owner;
    else begin
      for (int k = N - 1; k >= 0; k--)
        if (req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    end
    exp_rdy = load ? (1 << w) : 0;

    chk("out_valid", int'(out_valid), m_valid);
    chk("burst_end", int'(burst_end), m_be);
    chk("req_ready", int'(req_ready), exp_rdy);
    if (m_valid != 0) begin
      chk("out_data", int'(out_data), m_data);
      chk("out_sel", int'(out_sel), m_sel);
      sel_log.push_back(int'(out_sel));
      data_log.push_back(int'(out_data));
      be_log.push_back(int'(burst_end));
    end
    rdy_log.push_back(int'(req_ready));

    m_be = 0;
    if (load != 0) begin
      m_valid = 1;
      m_data  = int'(req_data[w]);
      m_sel   = w;
      if (m_hold != 0 && w == m_owner) m_cnt++;
      else begin
        m_owner = w;
        m_cnt   = 1;
      end
      if (m_cnt == MB) begin
        m_hold = 0;
        m_ptr  = (w + 1) % N;
        m_be   = 1;
      end else m_hold = 1;
    end else if (m_valid != 0 && out_ready) m_valid = 0;
    @(posedge clk);
    #1;
  endtask

  // asynchronous assert mid-cycle with every requester valid, synchronous release
  task automatic reset_async();
    @(negedge clk);
    req_valid = '1;
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_sel", int'(out_sel), 0);
    chk("rst_burst_end", int'(burst_end), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_req_ready_edge", int'(req_ready), 0);
    @(negedge clk);
    req_valid = '0;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_fair[10];
    int exp_be[10];
    int exp_drop[4];
    int frz_data, frz_sel;

    exp_fair = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    exp_be   = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    exp_drop = '{0, 1, 1, 3};

    rst = 1'b1;
    req_valid = '0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) req_data[i] = DW'(8'h10 + i);
    model_reset();

    repeat (2) @(posedge clk);
    @(negedge clk);
    req_valid = '1;
    #1;
    chk("init_out_valid", int'(out_valid), 0);
    chk("init_out_data", int'(out_data), 0);
    chk("init_req_ready", int'(req_ready), 0);
    req_valid = '0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // fairness
    req_valid = '1;
    out_ready = 1'b1;
    clear_logs();
    repeat (11) cycle();
    chk("fair_len", (sel_log.size() >= 10) ? 1 : 0, 1);
    for (int i = 0; i < 10 && i < sel_log.size(); i++) begin
      chk($sformatf("fair_sel[%0d]", i), sel_log[i], exp_fair[i]);
      chk($sformatf("fair_be[%0d]", i), be_log[i], exp_be[i]);
      chk($sformatf("fair_data[%0d]", i), data_log[i], 'h10 + exp_fair[i]);
    end

    // single requester
    req_valid = 4'b0100;
    req_data[2] = 8'h5A;
    clear_logs();
    repeat (8) cycle();
    for (int i = 1; i < data_log.size(); i++) begin
      chk($sformatf("single_data[%0d]", i), data_log[i], 'h5A);
      chk($sformatf("single_sel[%0d]", i), sel_log[i], 2);
    end
    req_data[2] = 8'h12;

    // backpressure
    req_valid = '1;
    out_ready = 1'b0;
    cycle();
    frz_data = int'(out_data);
    frz_sel  = int'(out_sel);
    clear_logs();
    repeat (5) cycle();
    for (int i = 0; i < rdy_log.size(); i++) begin
      chk($sformatf("bp_ready[%0d]", i), rdy_log[i], 0);
      chk($sformatf("bp_data[%0d]", i), data_log[i], frz_data);
      chk($sformatf("bp_sel[%0d]", i), sel_log[i], frz_sel);
    end
    out_ready = 1'b1;
    clear_logs();
    repeat (2) cycle();
    chk("bp_release_ready", (rdy_log[0] != 0) ? 1 : 0, 1);
    chk("bp_no_bubble", (data_log.size() == 2) ? 1 : 0, 1);

    // owner drop
    reset_async();
    req_valid = 4'b0001;
    cycle();
    req_valid = 4'b1010;
    clear_logs();
    repeat (4) cycle();
    chk("drop_len", (sel_log.size() == 4) ? 1 : 0, 1);
    for (int i = 0; i < 4 && i < sel_log.size(); i++)
      chk($sformatf("drop_sel[%0d]", i), sel_log[i], exp_drop[i]);

    // reset mid-burst
    reset_async();
    req_valid = 4'b0100;
    cycle();
    @(negedge clk);
    chk("mid_pre_valid", int'(out_valid), 1);
    chk("mid_pre_sel", int'(out_sel), 2);
    reset_async();
    req_valid = 4'b1010;
    clear_logs();
    repeat (2) cycle();
    chk("mid_restart_len", (sel_log.size() == 1) ? 1 : 0, 1);
    if (sel_log.size() > 0) chk("mid_restart_sel", sel_log[0], 1);

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) req_data[i] = DW'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
